// File: rtl/sd_emmc_controller_dma_mem_reader.sv
// SDMA host-to-card engine: fetches 32-bit words over the AXI read channel, one outstanding
// read at a time, and pushes them into the TX FIFO, pausing at SDMA buffer boundaries.
module sd_emmc_controller_dma_mem_reader #(
  parameter int BLKCNT_W      = 16,
  parameter int WORDS_PER_BLK = 128
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                dma_ena_trans_mode,
  input  logic                dir_dat_trans_mode,
  input  logic [31:0]         init_dma_sys_addr,
  input  logic [2:0]          buf_boundary,
  input  logic [BLKCNT_W-1:0] block_count,
  input  logic                sys_addr_changed,
  input  logic                is_fifo_full_wr,
  output logic                fifo_wr_en,
  output logic [31:0]         fifo_wr_data,
  output logic [31:0]         read_addr,
  output logic                addr_read_valid,
  input  logic                addr_read_ready,
  input  logic [31:0]         read_data,
  input  logic                data_read_valid,
  output logic                data_read_ready,
  output logic                dma_int,
  output logic                xfer_complete,
  output logic                busy
);

  localparam int WC_W = $clog2(WORDS_PER_BLK);

  typedef enum logic [2:0] {IDLE, FILL_WAIT, ADDR, DATA, BLK_END, BOUND_WAIT} state_t;

  state_t              state, state_nxt;
  logic [WC_W-1:0]     word_cnt;
  logic [BLKCNT_W-1:0] blk_done;
  logic [BLKCNT_W-1:0] blk_total;
  logic [10:0]         blk_in_bound;
  logic [10:0]         bound;
  logic                abort_pend;
  logic                start_ok;
  logic                last_word;

  assign start_ok  = start && dma_ena_trans_mode && !dir_dat_trans_mode;
  assign last_word = (word_cnt == WC_W'(WORDS_PER_BLK - 1));
  assign busy      = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    addr_read_valid = 1'b0;
    data_read_ready = 1'b0;
    case (state)
      IDLE:
        if (start_ok && block_count != '0) state_nxt = FILL_WAIT;
      FILL_WAIT:
        if (!dma_ena_trans_mode)   state_nxt = IDLE;
        else if (!is_fifo_full_wr) state_nxt = ADDR;
      ADDR: begin
        // Abort cannot cut an AXI handshake short; it is honoured after the beat.
        addr_read_valid = 1'b1;
        if (addr_read_ready) state_nxt = DATA;
      end
      DATA: begin
        data_read_ready = 1'b1;
        if (data_read_valid) begin
          if (abort_pend || !dma_ena_trans_mode) state_nxt = IDLE;
          else if (last_word)                    state_nxt = BLK_END;
          else                                   state_nxt = FILL_WAIT;
        end
      end
      BLK_END:
        if (!dma_ena_trans_mode)          state_nxt = IDLE;
        else if (blk_done == blk_total)   state_nxt = IDLE;
        else if (blk_in_bound == bound)   state_nxt = BOUND_WAIT;
        else                              state_nxt = FILL_WAIT;
      BOUND_WAIT:
        if (!dma_ena_trans_mode)    state_nxt = IDLE;
        else if (sys_addr_changed)  state_nxt = FILL_WAIT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fifo_wr_en    <= 1'b0;
      fifo_wr_data  <= '0;
      read_addr     <= '0;
      dma_int       <= 1'b0;
      xfer_complete <= 1'b0;
      word_cnt      <= '0;
      blk_done      <= '0;
      blk_total     <= '0;
      blk_in_bound  <= '0;
      bound         <= '0;
      abort_pend    <= 1'b0;
    end else begin
      fifo_wr_en    <= 1'b0;
      dma_int       <= 1'b0;
      xfer_complete <= 1'b0;
      case (state)
        IDLE: begin
          abort_pend <= 1'b0;
          if (start_ok) begin
            read_addr     <= init_dma_sys_addr;
            blk_total     <= block_count;
            bound         <= 11'd8 << buf_boundary;
            word_cnt      <= '0;
            blk_done      <= '0;
            blk_in_bound  <= '0;
            xfer_complete <= (block_count == '0);
          end
        end
        ADDR:
          if (!dma_ena_trans_mode) abort_pend <= 1'b1;
        DATA: begin
          if (!dma_ena_trans_mode) abort_pend <= 1'b1;
          if (data_read_valid) begin
            fifo_wr_en   <= 1'b1;
            fifo_wr_data <= read_data;
            read_addr    <= read_addr + 32'd4;
            if (last_word) begin
              word_cnt     <= '0;
              blk_done     <= blk_done + BLKCNT_W'(1);
              blk_in_bound <= blk_in_bound + 11'd1;
            end else begin
              word_cnt <= word_cnt + WC_W'(1);
            end
          end
        end
        BLK_END:
          if (dma_ena_trans_mode) begin
            // Completion wins over a boundary hit on the final block.
            if (blk_done == blk_total)    xfer_complete <= 1'b1;
            else if (blk_in_bound == bound) dma_int     <= 1'b1;
          end
        BOUND_WAIT:
          if (dma_ena_trans_mode && sys_addr_changed) begin
            read_addr    <= init_dma_sys_addr;
            blk_in_bound <= '0;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sd_emmc_controller_dma_mem_reader.md
Name: sd_emmc_controller_dma_mem_reader

Overview:
- SDMA engine for the host-to-card (write) direction.
- Fetches 32-bit words from system memory over the M_AXI read channel, one word per address/data handshake, and pushes them into the card-side TX FIFO.
- Honours the SDMA buffer-boundary pause, raising a DMA interrupt and waiting for a new system address before continuing.
- Signals transfer completion after block_count 512-byte blocks.

Parameters:
- BLKCNT_W, 16, width of the block count.
- WORDS_PER_BLK, 128, 32-bit words per block (512 B).

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that starts a transfer.
- dma_ena_trans_mode  in  1  DMA enable from the transfer mode register.
- dir_dat_trans_mode  in  1  transfer direction; 0 = write to card, the only direction this block serves.
- init_dma_sys_addr  in  32  SDMA system address.
- buf_boundary  in  3  host buffer boundary select.
- block_count  in  BLKCNT_W  number of blocks to transfer.
- sys_addr_changed  in  1  pulse when software rewrites the system address.
- is_fifo_full_wr  in  1  TX FIFO full.
- fifo_wr_en  out  1  one-cycle push strobe into the TX FIFO.
- fifo_wr_data  out  32  word being pushed.
- read_addr  out  32  M_AXI read address.
- addr_read_valid  out  1  read address valid.
- addr_read_ready  in  1  read address ready.
- read_data  in  32  M_AXI read data.
- data_read_valid  in  1  read data valid.
- data_read_ready  out  1  read data ready.
- dma_int  out  1  one-cycle pulse at a buffer boundary.
- xfer_complete  out  1  one-cycle pulse when the transfer finishes.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - All outputs are 0, read_addr = 0, state = IDLE.
  - Internal counters are cleared.
  - An async assert mid-transfer abandons the transfer silently: no dma_int, no xfer_complete.
- Boundary bound: blocks per boundary = 8 << buf_boundary (8..1024), i.e. 4 KB..512 KB. Latched at start.
- Counters:
  - word_cnt: 7 bits.
  - blk_done: BLKCNT_W bits.
  - blk_in_bound: 11 bits.
  - read_addr increments by 4 per accepted data beat, wrapping modulo 2^32.
- IDLE:
  - Exit requires start && dma_ena_trans_mode && !dir_dat_trans_mode.
  - On exit, latch read_addr = init_dma_sys_addr, latch block_count and bound, and clear counters.
  - If the latched block_count == 0, pulse xfer_complete on the next cycle and stay in IDLE.
  - Otherwise go to FILL_WAIT.
  - start with dir=1 or with DMA disabled is ignored.
- FILL_WAIT:
  - Wait while is_fifo_full_wr = 1.
  - When not full, go to ADDR.
  - This block is the only FIFO writer and keeps at most one read outstanding, so the slot is guaranteed at push time.
- ADDR:
  - addr_read_valid = 1, held with read_addr stable until addr_read_ready.
  - On the handshake cycle, drop valid and go to DATA.
- DATA:
  - data_read_ready = 1.
  - On data_read_valid: fifo_wr_en = 1 for exactly one cycle with fifo_wr_data = read_data (registered, one cycle after the beat), read_addr += 4, word_cnt += 1.
  - If word_cnt was WORDS_PER_BLK-1: blk_done += 1, blk_in_bound += 1, go to BLK_END. Otherwise go to FILL_WAIT.
- BLK_END:
  - If blk_done == block_count: pulse xfer_complete, go to IDLE. Completion takes priority over a boundary hit on the same block.
  - Else if blk_in_bound == bound: pulse dma_int, go to BOUND_WAIT.
  - Else go to FILL_WAIT.
- BOUND_WAIT:
  - Wait for sys_addr_changed.
  - On it: read_addr = init_dma_sys_addr, blk_in_bound = 0, go to FILL_WAIT.
  - sys_addr_changed is ignored in every other state.
- Abort (dma_ena_trans_mode = 0):
  - In IDLE, FILL_WAIT, BLK_END and BOUND_WAIT: return to IDLE next cycle, with no dma_int and no xfer_complete.
  - In ADDR or DATA: latch abort-pending, finish the current AXI handshake (the beat is still pushed), then go to IDLE. This keeps AXI legal.
- Latency: minimum 3 cycles per word (FILL_WAIT→ADDR→DATA) with ready/valid asserted immediately.
- start while busy is ignored.

Test Plan:
- block_count=1, buf_boundary=0, addr 0x1000_0000, memory responds in 0 wait states → 128 ADDR handshakes at 0x1000_0000..0x1000_01FC, 128 fifo_wr_en pulses with matching data, one xfer_complete, no dma_int.
- buf_boundary=0, block_count=10 → dma_int after block 8 with read_addr = 0x1000_1000. Stall until sys_addr_changed with new addr 0x2000_0000; blocks 9–10 read from 0x2000_0000..0x2000_03FC; then xfer_complete.
- block_count=8, buf_boundary=0 → xfer_complete only, no dma_int.
- is_fifo_full_wr held high for 50 cycles mid-block → addr_read_valid stays 0 throughout; resumes at the correct next address; no word lost or duplicated.
- addr_read_ready delayed 5 cycles → read_addr stable while valid. Then drop dma_ena_trans_mode during DATA → the pending beat is pushed, then IDLE, no xfer_complete.
- block_count=0 → xfer_complete one cycle after start, zero AXI activity. Async reset mid-DATA → all outputs 0 immediately.
